pipe_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It collects per-stage stall requests and the ID-stage branch/jump decision, and produces:
- hold (stall) enables for the PC and every pipeline register;
- bubble (flush) enables that insert NOPs behind a held stage;
- the PC redirect command.

It sits beside the pipeline registers and the PC unit. It also latches a branch decided while a later stage is stalled, so no redirect is lost.

---
 rtl/pipe_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard controller for the 5-stage core.
// Turns per-stage stall requests and the ID branch decision into hold
// enables, NOP-insert enables and a PC redirect. A branch resolved while
// EX/MEM is stalled is parked in pend_pc and replayed once they drain.
// A watchdog flags a stall that lasts STALL_TIMEOUT consecutive cycles.
// Optional feature macro: CTRL_PERF_EN (stall and redirect counters).
module pipe_ctrl #(
  parameter int STALL_TIMEOUT = 1024,
  parameter int ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              br_i,
  input  logic [ADDR_W-1:0] bt_i,
  output logic [4:0]        stall_o,
  output logic [4:0]        bubble_o,
  output logic              redirect_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              hang_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
);

  typedef enum logic {RUN, PEND} state_t;

  localparam logic [16:0] TIMEOUT_L = 17'(STALL_TIMEOUT);

  state_t              state_reg;
  logic [ADDR_W-1:0]   pend_pc_reg;
  logic [15:0]         stall_run_reg;
  logic                hang_reg;

  logic [4:0]          stall_next;
  logic [4:0]          bubble_next;
  logic                redirect_next;
  logic [ADDR_W-1:0]   pc_next;
  logic                go_pend;
  logic                any_stall;
  logic [16:0]         stall_run_inc;

  // Hazard decode: deepest requester holds itself and everything upstream,
  // a bubble goes into the stage just below it; redirects squash the fetch.
  always_comb begin
    stall_next    = 5'b00000;
    bubble_next   = 5'b00000;
    redirect_next = 1'b0;
    pc_next       = '0;
    go_pend       = 1'b0;
    if (!rst) begin
      if (stallreq_mem) begin
        stall_next  = 5'b01111;
        bubble_next = 5'b10000;
      end else if (stallreq_ex) begin
        stall_next  = 5'b00111;
        bubble_next = 5'b01000;
      end else if (stallreq_id) begin
        stall_next  = 5'b00011;
        bubble_next = 5'b00100;
      end else if (stallreq_if) begin
        stall_next  = 5'b00001;
        bubble_next = 5'b00010;
      end

      if (state_reg == RUN) begin
        if (br_i && !stallreq_id && !stallreq_ex && !stallreq_mem) begin
          redirect_next  = 1'b1;
          pc_next        = bt_i;
          stall_next[0]  = 1'b0;
          bubble_next[1] = 1'b1;
        end else if (br_i && (stallreq_ex || stallreq_mem)) begin
          go_pend = 1'b1;
        end
      end else begin
        // Replay the parked target once ID/EX/MEM are free; the re-asserted
        // br_i of the held ID instruction is deliberately ignored here.
        if (!stallreq_id && !stallreq_ex && !stallreq_mem) begin
          redirect_next  = 1'b1;
          pc_next        = pend_pc_reg;
          stall_next[0]  = 1'b0;
          bubble_next[1] = 1'b1;
        end
      end
    end
  end

  assign any_stall     = |stall_next;
  assign stall_run_inc = {1'b0, stall_run_reg} + 17'd1;

  assign stall_o    = stall_next;
  assign bubble_o   = bubble_next;
  assign redirect_o = redirect_next;
  assign pc_o       = pc_next;
  assign hang_o     = hang_reg;

  // State machine, pending target and saturating stall watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      pend_pc_reg   <= '0;
      stall_run_reg <= '0;
      hang_reg      <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (go_pend) begin
            state_reg   <= PEND;
            pend_pc_reg <= bt_i;
          end
        end
        PEND: begin
          if (redirect_next) begin
            state_reg <= RUN;
          end
        end
        default: state_reg <= RUN;
      endcase

      if (any_stall) begin
        if ({1'b0, stall_run_reg} < TIMEOUT_L) begin
          stall_run_reg <= stall_run_inc[15:0];
        end
        if (stall_run_inc >= TIMEOUT_L) begin
          hang_reg <= 1'b1;
        end
      end else begin
        stall_run_reg <= '0;
      end
    end
  end

`ifdef CTRL_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  // Free-running performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (any_stall)     stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (redirect_next) flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
  assign flush_cnt_o = flush_cnt_reg;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with STALL_TIMEOUT=4.
// Expected counter values depend on whether CTRL_PERF_EN is defined.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        br_i;
  logic [31:0] bt_i;
  logic [4:0]  stall_o, bubble_o;
  logic        redirect_o;
  logic [31:0] pc_o;
  logic        hang_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  int tests_run = 0;
  int tests_failed = 0;

  pipe_ctrl #(.STALL_TIMEOUT(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .br_i(br_i), .bt_i(bt_i),
    .stall_o(stall_o), .bubble_o(bubble_o),
    .redirect_o(redirect_o), .pc_o(pc_o), .hang_o(hang_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic f, input logic d, input logic e, input logic m,
                       input logic b, input logic [31:0] t);
    stallreq_if  = f;
    stallreq_id  = d;
    stallreq_ex  = e;
    stallreq_mem = m;
    br_i         = b;
    bt_i         = t;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the four combinational outputs in one call.
  task automatic check_out(input string tag, input logic [4:0] s, input logic [4:0] bb,
                           input logic r, input logic [31:0] p);
    check({tag, ".stall"},    64'(stall_o),    64'(s));
    check({tag, ".bubble"},   64'(bubble_o),   64'(bb));
    check({tag, ".redirect"}, 64'(redirect_o), 64'(r));
    check({tag, ".pc"},       64'(pc_o),       64'(p));
  endtask

  task automatic check_cnt(input string tag, input int sc, input int fc);
`ifdef CTRL_PERF_EN
    check({tag, ".stall_cnt"}, 64'(stall_cnt_o), 64'(sc));
    check({tag, ".flush_cnt"}, 64'(flush_cnt_o), 64'(fc));
`else
    check({tag, ".stall_cnt"}, 64'(stall_cnt_o), 64'(0));
    check({tag, ".flush_cnt"}, 64'(flush_cnt_o), 64'(0));
    if (sc < 0 || fc < 0) $display("[TB] note: negative count");
`endif
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 1, 1, 32'h40);
    tick();
    tick();
    // Outputs forced low while reset is high, even with requests present.
    check_out("in_reset", 5'b00000, 5'b00000, 1'b0, 32'h0);
    check("in_reset.hang", 64'(hang_o), 64'(0));
    drive(0, 0, 0, 0, 0, 32'h0);
    rst = 1'b0;
    #1;
    check_out("idle", 5'b00000, 5'b00000, 1'b0, 32'h0);
    check_cnt("after_reset", 0, 0);

    // EX busy for three cycles.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0, 32'h0);
      check_out($sformatf("ex_stall%0d", i), 5'b00111, 5'b01000, 1'b0, 32'h0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 32'h0);
    check_out("ex_release", 5'b00000, 5'b00000, 1'b0, 32'h0);
    check_cnt("after_ex", 3, 0);

    // Taken branch, no stall.
    drive(0, 0, 0, 0, 1, 32'h40);
    check_out("br_free", 5'b00000, 5'b00010, 1'b1, 32'h40);
    tick();
    drive(0, 0, 0, 0, 0, 32'h0);
    check_out("br_free_after", 5'b00000, 5'b00000, 1'b0, 32'h0);
    check_cnt("after_br", 3, 1);

    // Branch under MEM stall is deferred, target latched from first cycle.
    drive(0, 0, 0, 1, 1, 32'h100);
    check_out("pend_c1", 5'b01111, 5'b10000, 1'b0, 32'h0);
    tick();
    drive(0, 0, 0, 1, 1, 32'h200);
    check_out("pend_c2", 5'b01111, 5'b10000, 1'b0, 32'h0);
    tick();
    drive(0, 0, 0, 0, 1, 32'h300);
    check_out("pend_c3", 5'b00000, 5'b00010, 1'b1, 32'h100);
    tick();
    drive(0, 0, 0, 0, 0, 32'h0);
    check_out("pend_done", 5'b00000, 5'b00000, 1'b0, 32'h0);
    check_cnt("after_pend", 5, 2);

    // ID stall wins over branch.
    drive(0, 1, 0, 0, 1, 32'h80);
    check_out("id_br", 5'b00011, 5'b00100, 1'b0, 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 32'h0);
    check_out("id_br_after", 5'b00000, 5'b00000, 1'b0, 32'h0);
    tick();
    check_out("id_br_no_replay", 5'b00000, 5'b00000, 1'b0, 32'h0);

    // Branch with only an IF stall redirects and drops the PC hold.
    drive(1, 0, 0, 0, 1, 32'hC0);
    check_out("if_br", 5'b00000, 5'b00010, 1'b1, 32'hC0);
    tick();
    drive(0, 0, 0, 0, 0, 32'h0);
    tick();

    // Watchdog: IF stalled six cycles, hang after the fourth.
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 0, 0, 32'h0);
      check_out($sformatf("if_stall%0d", i), 5'b00001, 5'b00010, 1'b0, 32'h0);
      tick();
      check($sformatf("hang_c%0d", i + 1), 64'(hang_o), 64'((i + 1) >= 4));
    end
    drive(0, 0, 0, 0, 0, 32'h0);
    tick();
    check("hang_sticky1", 64'(hang_o), 64'(1));
    tick();
    check("hang_sticky2", 64'(hang_o), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("hang_cleared", 64'(hang_o), 64'(0));
    check_cnt("after_rst", 0, 0);

    // Enter PEND, then reset: pending target must be discarded.
    drive(0, 0, 1, 0, 1, 32'h500);
    check_out("pend2_enter", 5'b00111, 5'b01000, 1'b0, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    check_out("pend2_rst", 5'b00000, 5'b00000, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0);
    check_out("pend2_no_redirect", 5'b00000, 5'b00000, 1'b0, 32'h0);
    tick();
    check_out("pend2_no_redirect2", 5'b00000, 5'b00000, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
